// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Holds the funct3 op encoding, the FSM state codes, the divide-by-zero
// quotient constant and the negation/magnitude helpers.
// Helpers work on a fixed 2*MAX_XLEN container, so XLEN may not exceed MAX_XLEN.
package muldiv_pkg;

   localparam int unsigned MAX_XLEN = 64;

   typedef logic [2*MAX_XLEN-1:0] wide_t;

   // RISC-V M-extension funct3 encoding
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   // FSM state codes
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_FIX  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   // Quotient returned for division by zero (all ones, truncated to XLEN)
   localparam logic [MAX_XLEN-1:0] DIV_ZERO_QUOT = '1;

   // Two's-complement negate when neg is set
   function automatic wide_t cond_neg(input wide_t v, input logic neg);
      return neg ? (~v + wide_t'(1)) : v;
   endfunction

   // Magnitude of a zero-extended operand whose sign is given separately
   function automatic wide_t magnitude(input wide_t v, input logic is_neg);
      return cond_neg(v, is_neg);
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   kill                  synchronous abort, highest priority
//   in_valid/in_ready     request handshake; op (funct3), src_a, src_b
//   out_valid/out_ready   result handshake; result, zero
//   busy                  unit is not idle
// XLEN must be even, >= 4 and <= MAX_XLEN.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            kill,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   localparam int unsigned W2 = 2 * XLEN;
   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state_q, state_d;
   op_e             op_q, op_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, out_valid_q, in_ready_q, busy_q;

   // Request decode: operand signedness, magnitudes and result sign
   op_e             op_in;
   logic            signed_a, signed_b, sa, sb, res_neg;
   logic [XLEN-1:0] a_mag, b_mag;

   assign op_in    = op_e'(op);
   assign signed_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                     (op_in == OP_DIV)  || (op_in == OP_REM);
   assign signed_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
   assign sa       = signed_a & src_a[XLEN-1];
   assign sb       = signed_b & src_b[XLEN-1];
   assign res_neg  = (op_in == OP_REM) ? sa : (sa ^ sb);
   assign a_mag    = XLEN'(magnitude(wide_t'(src_a), sa));
   assign b_mag    = XLEN'(magnitude(wide_t'(src_b), sb));

   // Fast path: divide by zero and signed overflow resolve without iterating
   logic            div_zero, div_ovf, fast_hit;
   logic [XLEN-1:0] fast_val;

   assign div_zero = (src_b == '0);
   assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                     (src_a == MIN_NEG) && (src_b == '1);
   assign fast_hit = op[2] && (div_zero || div_ovf);
   assign fast_val = div_zero ? (op[1] ? src_a : XLEN'(DIV_ZERO_QUOT))
                              : (op[1] ? '0 : src_a);

   // Multiply step: add multiplicand into the upper half, shift right
   logic [XLEN:0] msum;
   assign msum = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);

   // Divide step: acc = {remainder, dividend/quotient}, shift left and trial subtract
   logic [XLEN:0] rem_sh, trial;
   assign rem_sh = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
   assign trial  = rem_sh - {1'b0, b_q};

   // Sign fix-up and field select
   logic [W2-1:0]   neg_wide;
   logic [XLEN-1:0] neg_lo, neg_hi, fix_val;

   assign neg_wide = W2'(cond_neg(wide_t'(acc_q), neg_q));
   assign neg_lo   = XLEN'(cond_neg(wide_t'(acc_q[XLEN-1:0]), neg_q));
   assign neg_hi   = XLEN'(cond_neg(wide_t'(acc_q[W2-1:XLEN]), neg_q));

   always_comb begin
      fix_val = neg_lo;
      case (op_q)
         OP_MUL:                        fix_val = neg_wide[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fix_val = neg_wide[W2-1:XLEN];
         OP_DIV, OP_DIVU:               fix_val = neg_lo;
         OP_REM, OP_REMU:               fix_val = neg_hi;
         default:                       fix_val = neg_lo;
      endcase
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;

      if (kill) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_d  = op_in;
                  neg_d = res_neg;
                  b_d   = b_mag;
                  acc_d = {{XLEN{1'b0}}, a_mag};
                  cnt_d = CW'(XLEN - 1);
                  if (fast_hit) begin
                     result_d = fast_val;
                     state_d  = ST_DONE;
                  end else begin
                     state_d  = ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (op_q[2]) begin
                  if (!trial[XLEN]) acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                  else              acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
               end else begin
                  acc_d = {msum, acc_q[XLEN-1:1]};
               end
               if (cnt_q == '0) state_d = ST_FIX;
               else             cnt_d   = cnt_q - CW'(1);
            end
            ST_FIX: begin
               result_d = fix_val;
               state_d  = ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_MUL;
         neg_q       <= 1'b0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         neg_q       <= neg_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         zero_q      <= (result_d == '0);
         out_valid_q <= (state_d == ST_DONE);
         in_ready_q  <= (state_d == ST_IDLE);
         busy_q      <= (state_d != ST_IDLE);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: XLEN=32 and XLEN=16 instances,
// table-driven vectors, a reference model for random ops, and hand-written
// back-pressure, kill and asynchronous-reset sequences.
module tb_muldiv_unit;

   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
   localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
   localparam int LAT   = 33;   // edges after the accepting edge, XLEN=32
   localparam int LAT16 = 17;
   localparam int FAST  = 0;    // fast path registers DONE on the accepting edge

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, kill;
   logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
   logic [2:0]  op_s;
   logic [31:0] src_a, src_b, result;

   logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16, zero_16, busy_16;
   logic [2:0]  op_16;
   logic [15:0] src_a_16, src_b_16, result_16;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .kill(kill),
      .in_valid(in_valid), .in_ready(in_ready), .op(op_s),
      .src_a(src_a), .src_b(src_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .busy(busy)
   );

   muldiv_unit #(.XLEN(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .kill(kill),
      .in_valid(in_valid_16), .in_ready(in_ready_16), .op(op_16),
      .src_a(src_a_16), .src_b(src_b_16),
      .out_valid(out_valid_16), .out_ready(out_ready_16),
      .result(result_16), .zero(zero_16), .busy(busy_16)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t        vecs [17];
   logic [31:0] sb [$];
   int          n_cmp  = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref32(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] sa, sbx, ua, ub, p;
      logic        ovf;
      sa  = {{32{a[31]}}, a};
      sbx = {{32{b[31]}}, b};
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (o)
         MUL:    begin p = ua * ub;  return p[31:0];  end
         MULH:   begin p = sa * sbx; return p[63:32]; end
         MULHSU: begin p = sa * ub;  return p[63:32]; end
         MULHU:  begin p = ua * ub;  return p[63:32]; end
         DIV:    begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return a;
            return 32'($signed(a) / $signed(b));
         end
         DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM:    begin
            if (b == 0) return a;
            if (ovf)    return 32'd0;
            return 32'($signed(a) % $signed(b));
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // One 32-bit op through both handshakes; hold = cycles of back-pressure in DONE
   task automatic run32(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input int hold);
      int          n;
      logic [31:0] want;
      @(negedge clk);
      check({name, " in_ready"}, 32'(in_ready), 32'd1);
      op_s = o; src_a = a; src_b = b; in_valid = 1'b1;
      @(posedge clk);
      sb.push_back(exp);
      #1;
      in_valid = 1'b0; src_a = $urandom; src_b = $urandom; op_s = 3'($urandom);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check({name, " latency"}, 32'(n), 32'(lat));
      want = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      check({name, " result"}, result, want);
      check({name, " zero"}, 32'(zero), 32'(want == 0));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, " held result"}, result, want);
         check({name, " held out_valid"}, 32'(out_valid), 32'd1);
         check({name, " held in_ready"}, 32'(in_ready), 32'd0);
         check({name, " held busy"}, 32'(busy), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, " released out_valid"}, 32'(out_valid), 32'd0);
      check({name, " released in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run16(input string name, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp, input int lat);
      int          n;
      logic [31:0] want;
      @(negedge clk);
      check({name, " in_ready"}, 32'(in_ready_16), 32'd1);
      op_16 = o; src_a_16 = a; src_b_16 = b; in_valid_16 = 1'b1;
      @(posedge clk);
      sb.push_back(32'(exp));
      #1;
      in_valid_16 = 1'b0; src_a_16 = 16'($urandom); src_b_16 = 16'($urandom);
      n = 0;
      while (!out_valid_16 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      check({name, " latency"}, 32'(n), 32'(lat));
      want = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      check({name, " result"}, 32'(result_16), want);
      check({name, " zero"}, 32'(zero_16), 32'(want == 0));
      check({name, " busy"}, 32'(busy_16), 32'd1);
      out_ready_16 = 1'b1;
      @(posedge clk); #1;
      out_ready_16 = 1'b0;
      check({name, " released"}, 32'(in_ready_16), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pulses;
      logic [2:0]  o;
      logic [31:0] a, b;

      vecs[0]  = '{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT};
      vecs[1]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT};
      vecs[2]  = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT};
      vecs[3]  = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT};
      vecs[4]  = '{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT};
      vecs[5]  = '{REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT};
      vecs[6]  = '{REMU,   32'h0000_0006, 32'h0000_0003, 32'h0000_0000, LAT};
      vecs[7]  = '{DIVU,   32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, FAST};
      vecs[8]  = '{REMU,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007, FAST};
      vecs[9]  = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST};
      vecs[10] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, FAST};
      vecs[11] = '{DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, LAT};
      vecs[12] = '{REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, LAT};
      vecs[13] = '{DIV,    32'h0000_0000, 32'h0000_0005, 32'h0000_0000, LAT};
      vecs[14] = '{MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, LAT};
      vecs[15] = '{DIV,    32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, FAST};
      vecs[16] = '{REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, FAST};

      rst_n = 1'b0; kill = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; op_s = MUL; src_a = '0; src_b = '0;
      in_valid_16 = 1'b0; out_ready_16 = 1'b0; op_16 = MUL; src_a_16 = '0; src_b_16 = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset result", result, 32'd0);
      check("reset zero", 32'(zero), 32'd1);
      check("reset16 in_ready", 32'(in_ready_16), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i])
         run32($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].exp, vecs[i].lat, 0);

      // Random ops against the reference model
      for (int i = 0; i < 10; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = (i % 2 == 1) ? 32'($urandom_range(1, 9)) : $urandom;
         run32($sformatf("rnd%0d", i), o, a, b, ref32(o, a, b), LAT, 0);
      end

      // Back-pressure in DONE
      run32("backpressure", MUL, 32'd3, 32'd5, 32'd15, LAT, 5);

      // kill 10 cycles into a DIV: no result, result register unchanged
      @(negedge clk);
      op_s = DIV; src_a = 32'd1000; src_b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1; kill = 1'b1;
      @(posedge clk); #1; kill = 1'b0;
      check("kill in_ready", 32'(in_ready), 32'd1);
      check("kill busy", 32'(busy), 32'd0);
      check("kill out_valid", 32'(out_valid), 32'd0);
      check("kill result kept", result, 32'd15);
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      check("kill no out_valid pulse", 32'(pulses), 32'd0);
      run32("after kill", MUL, 32'd3, 32'd4, 32'd12, LAT, 0);

      // kill together with in_valid in IDLE: nothing accepted
      @(negedge clk);
      op_s = MUL; src_a = 32'd2; src_b = 32'd2; in_valid = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; kill = 1'b0;
      check("kill+valid busy", 32'(busy), 32'd0);
      check("kill+valid in_ready", 32'(in_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("kill+valid out_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-CALC
      @(negedge clk);
      op_s = MUL; src_a = 32'd5; src_b = 32'd5; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async rst in_ready", 32'(in_ready), 32'd1);
      check("async rst busy", 32'(busy), 32'd0);
      check("async rst out_valid", 32'(out_valid), 32'd0);
      check("async rst result", result, 32'd0);
      check("async rst zero", 32'(zero), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run32("after reset", DIVU, 32'd81, 32'd9, 32'd9, LAT, 0);

      // XLEN=16 instance
      run16("x16 mulhu", MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, LAT16);
      run16("x16 div ovf", DIV, 16'h8000, 16'hFFFF, 16'h8000, FAST);
      run16("x16 div", DIV, 16'hFFF9, 16'h0002, 16'hFFFD, LAT16);
      run16("x16 remu", REMU, 16'd6, 16'd3, 16'd0, LAT16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
